// File: rtl/adder16_mp_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package adder16_mp_sequencer_pkg;

  localparam int unsigned LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder16_mp_sequencer_adder16.sv
// 16-bit carry-select adder: the low byte ripples, the high byte is computed
// for both carry-ins and picked by the low byte's carry-out.
module Adder16
  import adder16_mp_sequencer_pkg::*;
(
  input  logic [LIMB_W-1:0] in_A,
  input  logic [LIMB_W-1:0] in_B,
  input  logic              in_C,
  output logic [LIMB_W-1:0] out_S,
  output logic              out_C
);

  localparam int unsigned HALF = LIMB_W / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum0;
  logic [HALF:0] hi_sum1;

  always_comb begin
    lo_sum  = {1'b0, in_A[HALF-1:0]} + {1'b0, in_B[HALF-1:0]} + {{HALF{1'b0}}, in_C};
    hi_sum0 = {1'b0, in_A[LIMB_W-1:HALF]} + {1'b0, in_B[LIMB_W-1:HALF]};
    hi_sum1 = {1'b0, in_A[LIMB_W-1:HALF]} + {1'b0, in_B[LIMB_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};
    if (lo_sum[HALF]) begin
      out_S = {hi_sum1[HALF-1:0], lo_sum[HALF-1:0]};
      out_C = hi_sum1[HALF];
    end else begin
      out_S = {hi_sum0[HALF-1:0], lo_sum[HALF-1:0]};
      out_C = hi_sum0[HALF];
    end
  end

endmodule

// File: rtl/adder16_mp_sequencer.sv
// Multi-precision add/subtract: one 16-bit limb per clock through a shared
// Adder16, LS limb first, carry registered between limbs.
module adder16_mp_sequencer
  import adder16_mp_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      in_CLK,
  input  logic                      in_RSTn,
  input  logic                      in_VALID,
  output logic                      out_READY,
  input  logic [LIMB_W*WORDS-1:0]   in_A,
  input  logic [LIMB_W*WORDS-1:0]   in_B,
  input  logic                      in_C,
  input  logic                      in_SUB,
  output logic                      out_VALID,
  input  logic                      in_READY,
  output logic [LIMB_W*WORDS-1:0]   out_S,
  output logic                      out_C,
  output logic                      out_V,
  output logic                      out_BUSY
);

  localparam int unsigned CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t                    state, state_next;
  logic [CNT_W-1:0]          cnt;
  logic [LIMB_W*WORDS-1:0]   a_q, b_q;
  logic                      sub_q;
  logic                      carry_q;

  logic                      accept, step, last, drain;
  logic [LIMB_W-1:0]         limb_a, limb_b, limb_s;
  logic                      limb_c;

  always_comb begin
    limb_a = a_q[cnt*LIMB_W +: LIMB_W];
    limb_b = sub_q ? ~b_q[cnt*LIMB_W +: LIMB_W] : b_q[cnt*LIMB_W +: LIMB_W];
  end

  Adder16 u_adder16 (
    .in_A  (limb_a),
    .in_B  (limb_b),
    .in_C  (carry_q),
    .out_S (limb_s),
    .out_C (limb_c)
  );

  always_ff @(posedge in_CLK or negedge in_RSTn) begin
    if (!in_RSTn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: if (in_VALID) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: if (in_READY) begin
        drain      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge in_CLK or negedge in_RSTn) begin
    if (!in_RSTn) begin
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      out_S     <= '0;
      out_C     <= 1'b0;
      out_V     <= 1'b0;
      out_VALID <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= in_A;
        b_q     <= in_B;
        sub_q   <= in_SUB;
        carry_q <= in_SUB ? ~in_C : in_C;
        cnt     <= '0;
      end
      if (step) begin
        out_S[cnt*LIMB_W +: LIMB_W] <= limb_s;
        carry_q                     <= limb_c;
        // Counter returns to zero after the top limb so it never exceeds WORDS-1.
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (last) begin
        out_C     <= limb_c;
        out_V     <= (limb_a[LIMB_W-1] == limb_b[LIMB_W-1]) &&
                     (limb_s[LIMB_W-1] != limb_a[LIMB_W-1]);
        out_VALID <= 1'b1;
      end
      if (drain) out_VALID <= 1'b0;
    end
  end

  assign out_READY = (state == IDLE);
  assign out_BUSY  = (state == RUN);

endmodule
